// File: rtl/lc3_decode_out_queue.sv
// LC3 decode stage with a DEPTH-entry output queue toward execute.
// Each accepted instruction is decoded combinationally, stored as one bundle in
// the queue, and presented at the head under a valid/ready handshake.
module lc3_decode_out_queue #(
    parameter int unsigned XLEN  = 16,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable_decode,
    output logic            in_ready,
    input  logic [XLEN-1:0] IR_in,
    input  logic [XLEN-1:0] npc_in,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            Mem_Control,
    output logic [5:0]      E_Control,
    output logic [1:0]      W_Control,
    output logic [XLEN-1:0] IR,
    output logic [XLEN-1:0] npc_out,
    output logic            illegal,
    output logic [CntW-1:0] count
);

    typedef struct packed {
        logic            mem_ctl;
        logic [5:0]      e_ctl;
        logic [1:0]      w_ctl;
        logic            ill;
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          entry_in;
    entry_t          head;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Decode the incoming instruction into its control bundle.
    always_comb begin
        logic [1:0] alu;
        logic [1:0] ps1;
        logic       ps2;
        logic       op2;
        alu      = 2'b00;
        ps1      = 2'b00;
        ps2      = 1'b0;
        op2      = 1'b0;
        entry_in = '0;
        unique case (IR_in[15:12])
            4'b0001: op2 = ~IR_in[5];                          // ADD
            4'b0101: begin alu = 2'b01; op2 = ~IR_in[5]; end   // AND
            4'b1001: begin alu = 2'b10; op2 = 1'b1; end        // NOT
            4'b0000, 4'b0011, 4'b1011: begin ps1 = 2'b01; ps2 = 1'b1; end
            4'b0010, 4'b1010: begin
                ps1 = 2'b01; ps2 = 1'b1; entry_in.w_ctl = 2'd2;
            end
            4'b1110: begin ps1 = 2'b01; ps2 = 1'b1; entry_in.w_ctl = 2'd1; end
            4'b0110: begin ps1 = 2'b10; entry_in.w_ctl = 2'd2; end
            4'b0111: ps1 = 2'b10;
            4'b1100: ps1 = 2'b11;
            default: entry_in.ill = 1'b1;                      // RTI/JSR/TRAP/reserved
        endcase
        entry_in.mem_ctl = (IR_in[15:12] == 4'b1010) || (IR_in[15:12] == 4'b1011);
        entry_in.e_ctl   = {alu, ps1, ps2, op2};
        entry_in.ir      = IR_in;
        entry_in.npc     = npc_in;
    end

    assign in_ready  = (count_q != CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = enable_decode & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointer and occupancy next state; flush discards everything including a push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (!push && pop) count_d = count_q - CntW'(1);
        end
    end

    // Queue control state with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale contents are masked at the head, so no reset needed.
    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_ptr_q] <= entry_in;
    end

    // Head outputs are zero whenever the queue is empty.
    always_comb begin
        head = '0;
        if (out_valid) head = mem_q[rd_ptr_q];
    end

    assign Mem_Control = head.mem_ctl;
    assign E_Control   = head.e_ctl;
    assign W_Control   = head.w_ctl;
    assign IR          = head.ir;
    assign npc_out     = head.npc;
    assign illegal     = head.ill;
    assign count       = count_q;

endmodule

// File: tb/tb_lc3_decode_out_queue.sv
// Directed bench for lc3_decode_out_queue: DEPTH=2 main instance plus a DEPTH=3
// instance used for the asynchronous reset case.
module tb_lc3_decode_out_queue;

    logic        clock = 1'b0;
    logic        reset, rst2;
    logic        enable_decode, flush, out_ready;
    logic [15:0] IR_in, npc_in;

    logic        in_ready, out_valid, Mem_Control, illegal;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic [15:0] IR, npc_out;
    logic [1:0]  count;

    logic        in_ready2, out_valid2, Mem_Control2, illegal2;
    logic [5:0]  E_Control2;
    logic [1:0]  W_Control2;
    logic [15:0] IR2, npc_out2;
    logic [1:0]  count2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    lc3_decode_out_queue #(.XLEN(16), .DEPTH(2)) dut (
        .clock(clock), .reset(reset), .enable_decode(enable_decode), .in_ready(in_ready),
        .IR_in(IR_in), .npc_in(npc_in), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .Mem_Control(Mem_Control), .E_Control(E_Control),
        .W_Control(W_Control), .IR(IR), .npc_out(npc_out), .illegal(illegal), .count(count)
    );

    lc3_decode_out_queue #(.XLEN(16), .DEPTH(3)) dut3 (
        .clock(clock), .reset(rst2), .enable_decode(enable_decode), .in_ready(in_ready2),
        .IR_in(IR_in), .npc_in(npc_in), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid2), .Mem_Control(Mem_Control2), .E_Control(E_Control2),
        .W_Control(W_Control2), .IR(IR2), .npc_out(npc_out2), .illegal(illegal2),
        .count(count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Advance past the next rising edge; sample and drive 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; rst2 = 1'b1;
        enable_decode = 1'b0; flush = 1'b0; out_ready = 1'b0;
        IR_in = '0; npc_in = '0;
        #1;
        check("rst_count",    32'(count),     0);
        check("rst_in_ready", 32'(in_ready),  1);
        check("rst_valid",    32'(out_valid), 0);
        check("rst_ectl",     32'(E_Control), 0);
        tick(); tick();
        reset = 1'b0;

        // 1: ADD register form
        enable_decode = 1'b1; IR_in = 16'h1042; npc_in = 16'h3001; out_ready = 1'b1;
        tick();
        enable_decode = 1'b0;
        check("t1_valid", 32'(out_valid),   1);
        check("t1_ectl",  32'(E_Control),   'b000001);
        check("t1_wctl",  32'(W_Control),   0);
        check("t1_mctl",  32'(Mem_Control), 0);
        check("t1_npc",   32'(npc_out),     'h3001);
        tick();
        check("t1_empty", 32'(out_valid),   0);
        check("t1_ezero", 32'(npc_out),     0);

        // 2: LDI then AND immediate, held at the head
        out_ready = 1'b0; enable_decode = 1'b1; IR_in = 16'hA205; npc_in = 16'h3002;
        tick();
        check("t2_ldi_ectl", 32'(E_Control),   'b000110);
        check("t2_ldi_wctl", 32'(W_Control),   2);
        check("t2_ldi_mctl", 32'(Mem_Control), 1);
        check("t2_ldi_ill",  32'(illegal),     0);
        IR_in = 16'h5060;
        tick();
        enable_decode = 1'b0;
        check("t2_count",  32'(count), 2);
        check("t2_stable", 32'(IR),    'hA205);
        out_ready = 1'b1;
        tick();
        check("t2_and_ir",   32'(IR),        'h5060);
        check("t2_and_ectl", 32'(E_Control), 'b010000);
        check("t2_and_mctl", 32'(Mem_Control), 0);
        tick();
        check("t2_drained", 32'(count), 0);
        out_ready = 1'b0;

        // 3: fill to DEPTH, third push dropped, ordered drain
        enable_decode = 1'b1; IR_in = 16'h1042;
        tick();
        IR_in = 16'h2005;
        tick();
        check("t3_full_count", 32'(count),    2);
        check("t3_in_ready",   32'(in_ready), 0);
        IR_in = 16'h6040;
        tick();
        enable_decode = 1'b0;
        check("t3_drop_count", 32'(count), 2);
        check("t3_head0",      32'(IR),    'h1042);
        out_ready = 1'b1;
        tick();
        check("t3_head1",  32'(IR),        'h2005);
        check("t3_ld_ectl", 32'(E_Control), 'b000110);
        check("t3_ld_wctl", 32'(W_Control), 2);
        check("t3_count1", 32'(count),     1);
        tick();
        check("t3_count0", 32'(count),     0);
        check("t3_valid0", 32'(out_valid), 0);
        out_ready = 1'b0;

        // 4: simultaneous push and pop at count 1
        enable_decode = 1'b1; IR_in = 16'h1042;
        tick();
        IR_in = 16'h6040; npc_in = 16'h4000; out_ready = 1'b1;
        tick();
        enable_decode = 1'b0;
        check("t4_count", 32'(count),     1);
        check("t4_head",  32'(IR),        'h6040);
        check("t4_npc",   32'(npc_out),   'h4000);
        check("t4_ectl",  32'(E_Control), 'b001000);
        tick();
        out_ready = 1'b0;
        check("t4_empty", 32'(count), 0);

        // 5: flush with enable while full, then flush while not full
        enable_decode = 1'b1; IR_in = 16'h1042;
        tick();
        IR_in = 16'h2005;
        tick();
        check("t5_full", 32'(count), 2);
        flush = 1'b1; IR_in = 16'h5060;
        tick();
        check("t5_count", 32'(count),     0);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_ir",    32'(IR),        0);
        check("t5_npc",   32'(npc_out),   0);
        check("t5_ectl",  32'(E_Control), 0);
        check("t5_wctl",  32'(W_Control), 0);
        flush = 1'b0; IR_in = 16'h1042;
        tick();
        flush = 1'b1;
        #1;
        check("t5_rdy_flush", 32'(in_ready), 1);
        tick();
        flush = 1'b0; enable_decode = 1'b0;
        check("t5_flush2", 32'(count), 0);

        // 6: TRAP is illegal with zero controls
        enable_decode = 1'b1; IR_in = 16'hF025; npc_in = 16'h5000;
        tick();
        enable_decode = 1'b0;
        check("t6_ill",  32'(illegal),     1);
        check("t6_ectl", 32'(E_Control),   0);
        check("t6_wctl", 32'(W_Control),   0);
        check("t6_mctl", 32'(Mem_Control), 0);
        check("t6_ir",   32'(IR),          'hF025);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 6b: asynchronous reset mid-burst on the DEPTH=3 instance
        rst2 = 1'b0;
        enable_decode = 1'b1; IR_in = 16'h1042;
        tick();
        IR_in = 16'h2005;
        tick();
        IR_in = 16'h6040;
        tick();
        enable_decode = 1'b0;
        check("t6_d3_count", 32'(count2),    3);
        check("t6_d3_rdy",   32'(in_ready2), 0);
        check("t6_d3_head",  32'(IR2),       'h1042);
        #2;
        rst2 = 1'b1; reset = 1'b1;
        #1;
        check("t6_arst_count", 32'(count2),     0);
        check("t6_arst_valid", 32'(out_valid2), 0);
        check("t6_arst_ir",    32'(IR2),        0);
        check("t6_arst_npc",   32'(npc_out2),   0);
        check("t6_arst_rdy",   32'(in_ready2),  1);
        check("t6_arst_main",  32'(count),      0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
